omsp_spm_ctrl_gen2: RTL

OMSP_SPM_CTRL_GEN2 -- requirements
Module: omsp_spm_ctrl_gen2

---
 rtl/omsp_spm_ctrl_gen2.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/omsp_spm_ctrl_gen2.sv
// omsp_spm_ctrl_gen2
// Protection-module controller: allocates module slots on create requests,
// broadcasts destroy requests, tracks the executing module ID with a bounded
// caller-ID history stack, and raises the global protection violation flag.
module omsp_spm_ctrl_gen2 #(
  parameter int NB_SMS      = 4,
  parameter int ID_W        = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                   mclk,
  input  logic                   puc_rst,
  input  logic                   req_valid,
  input  logic                   req_enable,
  output logic                   req_ready,
  output logic                   done,
  output logic                   done_ok,
  input  logic [NB_SMS-1:0]      sms_enabled,
  input  logic [NB_SMS-1:0]      sms_executing,
  input  logic [NB_SMS*ID_W-1:0] sms_id,
  input  logic [NB_SMS-1:0]      sms_violation,
  input  logic                   handling_irq,
  input  logic [3:0]             irq_num,
  output logic [NB_SMS-1:0]      sms_update,
  output logic [NB_SMS-1:0]      sms_check,
  output logic [ID_W-1:0]        next_id,
  output logic [ID_W-1:0]        current_id,
  output logic [ID_W-1:0]        prev_id,
  output logic                   enter_sm,
  output logic                   violation
);

  localparam int IDX_W = $clog2(NB_SMS);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);

  // Interrupt pseudo-IDs occupy the top 16 values of the ID space.
  localparam logic [ID_W-1:0]  IRQ_BASE   = {{(ID_W-4){1'b1}}, 4'b0000};
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NB_SMS - 1);
  localparam logic [SP_W-1:0]  STACK_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    COMMIT,
    DISABLE,
    FAIL
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [NB_SMS-1:0] idx_onehot;

  logic [ID_W-1:0]   exec_id;
  logic [ID_W-1:0]   cur_q;
  logic [ID_W-1:0]   stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_pop;
  logic              stack_push;

  assign idx_onehot = NB_SMS'(1) << idx;

  // ---------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: walk slots looking for the first free one.
  // NOTE: defaults assigned up front so no path leaves a variable unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!req_enable)                state_nxt = DISABLE;
          else if (next_id == IRQ_BASE)   state_nxt = FAIL;
          else                            state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (!sms_enabled[idx])            state_nxt = COMMIT;
        else if (idx == LAST_IDX)         state_nxt = FAIL;
      end
      COMMIT, DISABLE, FAIL:              state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Output logic: strobes and completion pulse decoded from the state.
  always_comb begin
    req_ready  = 1'b0;
    done       = 1'b0;
    done_ok    = 1'b0;
    sms_update = '0;
    sms_check  = '0;
    case (state)
      IDLE:    req_ready = 1'b1;
      COMMIT: begin
        done       = 1'b1;
        done_ok    = ~|sms_violation;
        sms_update = idx_onehot;
        sms_check  = sms_enabled & ~idx_onehot;
      end
      DISABLE: begin
        done       = 1'b1;
        done_ok    = 1'b1;
        sms_update = '1;
      end
      FAIL:    done = 1'b1;
      default: ;
    endcase
  end

  // Slot index: restarts at 0 in IDLE, advances past occupied slots in SCAN
  // and holds the free slot through COMMIT.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst)                                          idx <= '0;
    else if (state == IDLE)                               idx <= '0;
    else if (state == SCAN && sms_enabled[idx] && idx != LAST_IDX)
                                                          idx <= idx + IDX_W'(1);
  end

  // ID allocator: advances only on a clean commit; saturates at IRQ_BASE
  // because creates at that value are routed to FAIL.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst)                                  next_id <= ID_W'(1);
    else if (state == COMMIT && !(|sms_violation)) next_id <= next_id + ID_W'(1);
  end

  // ---------------------------------------------------------------------
  // Execution tracking
  // ---------------------------------------------------------------------

  // Executing ID: interrupt pseudo-ID wins, else the executing slot's ID.
  always_comb begin
    exec_id = '0;
    for (int i = 0; i < NB_SMS; i++) begin
      if (sms_executing[i]) exec_id = sms_id[i*ID_W +: ID_W];
    end
    current_id = handling_irq ? (IRQ_BASE + ID_W'(irq_num)) : exec_id;
  end

  // Previous-cycle copy of the executing ID.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) cur_q <= '0;
    else         cur_q <= current_id;
  end

  assign enter_sm    = (current_id != cur_q);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == STACK_FULL);

  // Caller ID is the stack top, or 0 when nothing has been pushed.
  always_comb begin
    prev_id = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) prev_id = stack_mem[i];
    end
  end

  // Returning to the caller pops; any other transition is a call.
  assign stack_pop  = enter_sm && !stack_empty && (current_id == prev_id);
  assign stack_push = enter_sm && !stack_pop;

  // Stack contents: a full stack shifts down, losing its oldest entry.
  // NOTE: entries carry no reset; the pointer alone marks them valid and
  // prev_id never selects an entry above it.
  always_ff @(posedge mclk) begin
    if (stack_push) begin
      if (stack_full) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) stack_mem[i] <= stack_mem[i+1];
        stack_mem[STACK_DEPTH-1] <= cur_q;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (sp == SP_W'(i)) stack_mem[i] <= cur_q;
        end
      end
    end
  end

  // Stack pointer.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst)                       sp <= '0;
    else if (stack_push && !stack_full) sp <= sp + SP_W'(1);
    else if (stack_pop)                sp <= sp - SP_W'(1);
  end

  assign violation = (|sms_violation) | (next_id == IRQ_BASE);

endmodule
